guvm_data_mem: RTL and testbench
================================

GUVM_DATA_MEM -- requirements
Module: guvm_data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: memory size in 32-bit words, power of two.
REQ-002 SHALL have parameter GNT_DELAY, default 0: idle cycles (0..7) between req assertion and gnt.
REQ-003 SHALL have parameter RVALID_LAT, default 1: cycles (1..4) from gnt to rvalid.
REQ-004 SHALL have port clk_i, input, 1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports data_req_i, data_we_i (input, 1): core request and write strobe.
REQ-007 SHALL have ports data_be_i (input, 4), data_addr_i (input, 32) and data_wdata_i (input, 32): core byte enables, byte address and write data.
REQ-008 SHALL have ports data_gnt_o, data_rvalid_o, data_err_o (output, 1): grant, response valid and error.
REQ-009 SHALL have port data_rdata_o, output, 32: read response data.
REQ-010 SHALL have ports bd_we_i (input, 1), bd_addr_i (input, 32) and bd_wdata_i (input, 32): testbench backdoor word write.

Function
REQ-011 SHALL implement FSM IDLE -> WAIT -> GRANT. IDLE: waiting for a request. WAIT: GNT_DELAY countdown. GRANT: data_gnt_o=1 for exactly one cycle.
REQ-012 SHALL move from IDLE to GRANT when data_req_i=1 and GNT_DELAY=0; otherwise SHALL move to WAIT and load the counter with GNT_DELAY-1.
REQ-013 SHALL, in WAIT, decrement the counter and enter GRANT when it reaches 0; if data_req_i drops during WAIT, SHALL return to IDLE without granting.
REQ-014 SHALL, after GRANT, go to IDLE, or when GNT_DELAY=0 and data_req_i=1, grant again the next cycle (back-to-back, one transaction per cycle).
REQ-015 SHALL sample we, be, addr and wdata only in the cycle data_gnt_o=1.
REQ-016 SHALL form the word index as addr[2 +: log2(DEPTH_WORDS)] and ignore addr[1:0].
REQ-017 SHALL treat addr >= 4*DEPTH_WORDS as out of range: no write, rdata=32'hDEAD_BEEF, err=1.
REQ-018 SHALL commit granted writes at the grant edge, updating only bytes with be[i]=1; be=0 is a legal no-op write.
REQ-019 SHALL, for reads, return the full word as read at the grant edge, ignoring be; a write granted in cycle N SHALL be visible to a read granted in cycle N+1.
REQ-020 SHALL assert data_rvalid_o for one cycle exactly RVALID_LAT cycles after each gnt (reads and writes), in grant order.
REQ-021 SHALL carry rdata and err through a RVALID_LAT-stage shift pipeline; write responses SHALL give rdata=0 and err=0 unless out of range.
REQ-022 SHALL hold rdata, err and rvalid at 0 when rvalid is not asserted.
REQ-023 SHALL apply a backdoor write (full word) at the clock edge when bd_we_i=1; a simultaneous bus write to the same word SHALL win.
REQ-024 SHALL ignore an out-of-range backdoor address.

Reset
REQ-025 SHALL, on rst_ni=0, immediately force the FSM to IDLE, the counter to 0, and the response pipeline empty.
REQ-026 SHALL drive data_gnt_o, data_rvalid_o, data_err_o=0 and data_rdata_o=0 while in reset.
REQ-027 SHALL drop responses still in flight when reset asserts mid-transaction, and SHALL NOT emit them after release.
REQ-028 SHALL NOT reset memory contents.

Structure
REQ-029 SHALL place the FSM state enum, the DEAD_BEEF constant and the parameter range limits in shared package guvm_mem_pkg.
REQ-030 SHALL put the response shift pipeline in one sub-module, guvm_rsp_pipe, parameterised by RVALID_LAT.

Verification
REQ-031 SHALL cover, with defaults: backdoor 0x10 <- 0x11223344, then read addr 0x40 -> gnt in the req cycle, rvalid next cycle, rdata=0x11223344.
REQ-032 SHALL cover: write addr 0x40, be=4'b0101, wdata=0xAABBCCDD over 0x11223344, then read -> rdata=0x11BB33DD.
REQ-033 SHALL cover, with GNT_DELAY=3: req held -> gnt on the 4th cycle; req dropped after 2 cycles -> no gnt, FSM back in IDLE.
REQ-034 SHALL cover: read addr 0x400 with DEPTH_WORDS=256 -> rvalid with err=1, rdata=0xDEADBEEF; memory unchanged.
REQ-035 SHALL cover, with RVALID_LAT=3: back-to-back write 0x0 <- 0x5, then read 0x0 -> two rvalids 3 cycles after their gnts, read data 0x5.
REQ-036 SHALL cover, with RVALID_LAT=3: assert rst_ni=0 one cycle after gnt -> no rvalid during or after reset; memory word retains its value.

Source files
------------

// File: rtl/guvm_mem_pkg.sv
// Shared definitions for the guvm data memory model.
//   mem_state_e      : grant FSM states (IDLE -> WAIT -> GRANT)
//   DEAD_BEEF        : read data returned for out-of-range accesses
//   *_MIN / *_MAX    : legal ranges of the GNT_DELAY and RVALID_LAT parameters
//   CNT_W            : width of the grant-delay counter (covers 0..GNT_DELAY_MAX)
package guvm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } mem_state_e;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    localparam int GNT_DELAY_MIN  = 0;
    localparam int GNT_DELAY_MAX  = 7;
    localparam int RVALID_LAT_MIN = 1;
    localparam int RVALID_LAT_MAX = 4;

    localparam int CNT_W = 3;

endpackage

// File: rtl/guvm_rsp_pipe.sv
// Response shift pipeline: a granted transaction enters stage 0 and leaves
// RVALID_LAT cycles later on the outputs.
//   clk_i, rst_ni        : clock, asynchronous active-low reset (empties pipe)
//   in_valid_i           : a transaction was granted this cycle
//   in_rdata_i, in_err_i : its response data / error flag
//   rvalid_o, rdata_o, err_o : response, all zero when no response is due
module guvm_rsp_pipe #(
    parameter int RVALID_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [RVALID_LAT-1:0] valid_q, valid_d;
    logic [RVALID_LAT-1:0] err_q, err_d;
    logic [31:0]           rdata_q [RVALID_LAT];
    logic [31:0]           rdata_d [RVALID_LAT];

    // Data is zeroed on entry when no transaction is granted, so every
    // stage (and therefore the output) is zero whenever it carries no response.
    always_comb begin
        valid_d    = valid_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        valid_d[0] = in_valid_i;
        err_d[0]   = in_valid_i & in_err_i;
        rdata_d[0] = in_valid_i ? in_rdata_i : 32'd0;
        for (int i = 1; i < RVALID_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < RVALID_LAT; i++) begin
                rdata_q[i] <= 32'd0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign rvalid_o = valid_q[RVALID_LAT-1];
    assign err_o    = err_q[RVALID_LAT-1];
    assign rdata_o  = rdata_q[RVALID_LAT-1];

endmodule

// File: rtl/guvm_data_mem.sv
// Core data-side memory with configurable grant delay and response latency.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   data_req_i, data_we_i  : request and write strobe
//   data_be_i              : byte enables for writes
//   data_addr_i            : byte address (bits [1:0] ignored)
//   data_wdata_i           : write data
//   data_gnt_o             : grant, one per accepted transaction
//   data_rvalid_o, data_rdata_o, data_err_o : response, RVALID_LAT after grant
//   bd_we_i, bd_addr_i, bd_wdata_i : backdoor full-word write, bd_addr_i is a word index
module guvm_data_mem
    import guvm_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int GNT_DELAY   = 0,
    parameter int RVALID_LAT  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        bd_we_i,
    input  logic [31:0] bd_addr_i,
    input  logic [31:0] bd_wdata_i
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic NO_DELAY = (GNT_DELAY == 0);
    localparam logic [CNT_W-1:0] DELAY_LOAD = NO_DELAY ? '0 : CNT_W'(GNT_DELAY - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt;

    // ---------------- grant FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (data_req_i) begin
                    if (NO_DELAY) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = DELAY_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!data_req_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_GRANT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GRANT: begin
                state_d = (NO_DELAY && data_req_i) ? ST_GRANT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The grant is issued in the cycle the FSM commits to GRANT, which makes
    // a zero-delay grant land in the same cycle as the request. Every path
    // into GRANT requires data_req_i, so no grant appears without a request.
    assign gnt        = rst_ni && (state_d == ST_GRANT);
    assign data_gnt_o = gnt;

    // ---------------- memory ----------------
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] word_idx, bd_idx;
    logic          in_range, bd_in_range, bus_wr;
    logic [31:0]   rsp_rdata;

    assign word_idx    = data_addr_i[2 +: AW];
    assign in_range    = (data_addr_i >> (AW + 2)) == 32'd0;
    assign bd_idx      = bd_addr_i[AW-1:0];
    assign bd_in_range = (bd_addr_i >> AW) == 32'd0;
    assign bus_wr      = gnt && data_we_i && in_range;

    // Backdoor first, bus second: on a same-word collision the later
    // non-blocking assignment (the bus write) wins.
    always_ff @(posedge clk_i) begin
        if (bd_we_i && bd_in_range) begin
            mem_q[bd_idx] <= bd_wdata_i;
        end
        if (bus_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_i[i]) begin
                    mem_q[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read data is captured by the first pipeline stage at the grant edge,
    // so it is the word as it stood before any write on that same edge.
    always_comb begin
        rsp_rdata = mem_q[word_idx];
        if (!in_range) begin
            rsp_rdata = DEAD_BEEF;
        end else if (data_we_i) begin
            rsp_rdata = 32'd0;
        end
    end

    guvm_rsp_pipe #(
        .RVALID_LAT (RVALID_LAT)
    ) u_rsp_pipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (gnt),
        .in_rdata_i (rsp_rdata),
        .in_err_i   (!in_range),
        .rvalid_o   (data_rvalid_o),
        .rdata_o    (data_rdata_o),
        .err_o      (data_err_o)
    );

endmodule

// File: tb/tb_guvm_data_mem.sv
// Bench for guvm_data_mem: three instances (defaults, GNT_DELAY=3,
// RVALID_LAT=3) driven with directed vectors and randomized traffic checked
// against a word-array model with a cycle-indexed expected-response table.
module tb_guvm_data_mem;

    logic        clk;
    logic        rst_n    [3];
    logic        req      [3];
    logic        we       [3];
    logic [3:0]  be       [3];
    logic [31:0] addr     [3];
    logic [31:0] wdata    [3];
    logic        gnt      [3];
    logic        rvalid   [3];
    logic [31:0] rdata    [3];
    logic        err      [3];
    logic        bd_we    [3];
    logic [31:0] bd_addr  [3];
    logic [31:0] bd_wdata [3];

    logic [31:0] model [3][16];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    guvm_data_mem #(.DEPTH_WORDS(256), .GNT_DELAY(0), .RVALID_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .data_req_i(req[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
        .data_err_o(err[0]), .bd_we_i(bd_we[0]), .bd_addr_i(bd_addr[0]), .bd_wdata_i(bd_wdata[0]));

    guvm_data_mem #(.DEPTH_WORDS(256), .GNT_DELAY(3), .RVALID_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .data_req_i(req[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
        .data_err_o(err[1]), .bd_we_i(bd_we[1]), .bd_addr_i(bd_addr[1]), .bd_wdata_i(bd_wdata[1]));

    guvm_data_mem #(.DEPTH_WORDS(256), .GNT_DELAY(0), .RVALID_LAT(3)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .data_req_i(req[2]), .data_we_i(we[2]),
        .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
        .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]),
        .data_err_o(err[2]), .bd_we_i(bd_we[2]), .bd_addr_i(bd_addr[2]), .bd_wdata_i(bd_wdata[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic v, input logic e, input logic [31:0] d);
        return {30'd0, v, e, d};
    endfunction

    function automatic logic [63:0] rsp_of(input int k);
        return {30'd0, rvalid[k], err[k], rdata[k]};
    endfunction

    task automatic idle(input int k);
        req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'd0; wdata[k] = 32'd0;
    endtask

    task automatic bd_idle(input int k);
        bd_we[k] = 1'b0; bd_addr[k] = 32'd0; bd_wdata[k] = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic preload();
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 3; k++) begin
                bd_we[k] = 1'b1; bd_addr[k] = w; bd_wdata[k] = $urandom;
                model[k][w] = bd_wdata[k];
            end
            step();
        end
        for (int k = 0; k < 3; k++) bd_idle(k);
    endtask

    // One transaction on a RVALID_LAT=1, zero-delay instance.
    task automatic do_txn(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                          input string tag);
        idle(k);
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = wd;
        mid();
        check({tag, "_gnt"}, 64'(gnt[k]), 64'd1);
        check({tag, "_quiet"}, rsp_of(k), 64'd0);
        step();
        idle(k);
        bd_idle(k);
        mid();
        check({tag, "_nognt"}, 64'(gnt[k]), 64'd0);
        check({tag, "_rsp"}, rsp_of(k), mk(1'b1, exp_e, exp_d));
        $display("txn %s we=%0b be=%b addr=%h -> rvalid=%0b err=%0b rdata=%h",
                 tag, w, b, a, rvalid[k], err[k], rdata[k]);
        step();
    endtask

    // GNT_DELAY=3 instance: hold a read of word 2, drop req after the grant.
    task automatic gd_seq(input string tag);
        int first;
        int gcount;
        first = 0;
        gcount = 0;
        idle(1);
        req[1] = 1'b1; addr[1] = 32'h8;
        for (int c = 1; c <= 8; c++) begin
            mid();
            if (first != 0 && c == first + 1)
                check({tag, "_rsp"}, rsp_of(1), mk(1'b1, 1'b0, model[1][2]));
            if (gnt[1]) begin
                gcount++;
                if (first == 0) first = c;
            end
            step();
            if (first != 0) req[1] = 1'b0;
        end
        check({tag, "_gnt_cycle"}, 64'(first), 64'd4);
        check({tag, "_gnt_count"}, 64'(gcount), 64'd1);
        $display("txn %s: grant in cycle %0d, %0d grant(s)", tag, first, gcount);
    endtask

    // Randomized traffic against the model. A response due at cycle c+lat is
    // recorded when the request is granted in cycle c.
    task automatic run_random(input int k, input int lat, input int n);
        logic [63:0] exp_rsp [0:299];
        logic        oor;
        int          widx;
        int          sel;
        for (int i = 0; i < 300; i++) exp_rsp[i] = 64'd0;
        for (int c = 0; c < n + lat + 2; c++) begin
            idle(k);
            bd_idle(k);
            if (c < n) begin
                req[k]   = ($urandom_range(0, 3) != 0);
                we[k]    = $urandom_range(0, 1);
                be[k]    = 4'($urandom_range(0, 15));
                wdata[k] = $urandom;
                sel      = $urandom_range(0, 9);
                if (sel == 0)
                    addr[k] = 32'h400 + 32'($urandom_range(0, 15) * 4);
                else if (sel == 1)
                    addr[k] = $urandom | 32'h8000_0000;
                else
                    addr[k] = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0) begin
                    bd_we[k]    = 1'b1;
                    bd_addr[k]  = ($urandom_range(0, 4) == 0) ? 32'(256 + $urandom_range(0, 15))
                                                              : 32'($urandom_range(0, 15));
                    bd_wdata[k] = $urandom;
                end
            end
            oor  = (addr[k] >= 32'h400);
            widx = oor ? 0 : int'(addr[k] / 4);
            if (req[k]) begin
                if (oor)
                    exp_rsp[c + lat] = mk(1'b1, 1'b1, 32'hDEAD_BEEF);
                else if (we[k])
                    exp_rsp[c + lat] = mk(1'b1, 1'b0, 32'd0);
                else
                    exp_rsp[c + lat] = mk(1'b1, 1'b0, model[k][widx]);
            end
            if (bd_we[k] && bd_addr[k] < 32'd16)
                model[k][bd_addr[k]] = bd_wdata[k];
            if (req[k] && we[k] && !oor)
                for (int b = 0; b < 4; b++)
                    if (be[k][b]) model[k][widx][8*b +: 8] = wdata[k][8*b +: 8];
            mid();
            check($sformatf("rnd%0d_gnt c=%0d", k, c), 64'(gnt[k]), 64'(req[k]));
            check($sformatf("rnd%0d_rsp c=%0d", k, c), rsp_of(k), exp_rsp[c]);
            step();
        end
        idle(k);
        bd_idle(k);
        $display("txn random run on instance %0d (lat %0d, %0d cycles) done", k, lat, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [13];
        logic [63:0] ex;

        vecs[0]  = '{1'b0, 4'hF, 32'h40,  32'h0,          32'h11223344, 1'b0};
        vecs[1]  = '{1'b1, 4'h5, 32'h40,  32'hAABBCCDD,   32'h0,        1'b0};
        vecs[2]  = '{1'b0, 4'h0, 32'h40,  32'h0,          32'h11BB33DD, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 32'h43,  32'h0,          32'h11BB33DD, 1'b0};
        vecs[4]  = '{1'b1, 4'h0, 32'h40,  32'hFFFFFFFF,   32'h0,        1'b0};
        vecs[5]  = '{1'b0, 4'hF, 32'h40,  32'h0,          32'h11BB33DD, 1'b0};
        vecs[6]  = '{1'b1, 4'hF, 32'h400, 32'h12345678,   32'hDEADBEEF, 1'b1};
        vecs[7]  = '{1'b0, 4'hF, 32'h400, 32'h0,          32'hDEADBEEF, 1'b1};
        vecs[8]  = '{1'b0, 4'hF, 32'h0,   32'h0,          32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 4'hF, 32'h3FC, 32'h0BADC0DE,   32'h0,        1'b0};
        vecs[10] = '{1'b0, 4'hF, 32'h3FC, 32'h0,          32'h0BADC0DE, 1'b0};
        vecs[11] = '{1'b1, 4'hA, 32'h40,  32'h55667788,   32'h0,        1'b0};
        vecs[12] = '{1'b0, 4'hF, 32'h40,  32'h0,          32'h55BB77DD, 1'b0};

        // Reset: outputs quiet even with a request pending.
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; idle(k); bd_idle(k); req[k] = 1'b1;
        end
        mid();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_gnt%0d", k), 64'(gnt[k]), 64'd0);
            check($sformatf("reset_rsp%0d", k), rsp_of(k), 64'd0);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b1; idle(k);
        end
        step();
        preload();

        // Directed table on the default instance.
        bd_we[0] = 1'b1; bd_addr[0] = 32'h10; bd_wdata[0] = 32'h11223344;
        step();
        bd_addr[0] = 32'h0; bd_wdata[0] = 32'hCAFEF00D;
        step();
        bd_idle(0);
        for (int i = 0; i < 13; i++)
            do_txn(0, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].wd, vecs[i].exp_d, vecs[i].exp_e,
                   $sformatf("vec%0d", i));

        // Same-word collision: the bus write wins over the backdoor.
        bd_we[0] = 1'b1; bd_addr[0] = 32'h20; bd_wdata[0] = 32'hBBBB1111;
        do_txn(0, 1'b1, 4'hF, 32'h80, 32'hAAAA0000, 32'h0, 1'b0, "coll_wr");
        do_txn(0, 1'b0, 4'hF, 32'h80, 32'h0, 32'hAAAA0000, 1'b0, "coll_rd");
        // Different words in the same cycle: both land.
        bd_we[0] = 1'b1; bd_addr[0] = 32'h22; bd_wdata[0] = 32'h00000002;
        do_txn(0, 1'b1, 4'hF, 32'h84, 32'h00000001, 32'h0, 1'b0, "split_wr");
        do_txn(0, 1'b0, 4'hF, 32'h84, 32'h0, 32'h00000001, 1'b0, "split_rd_bus");
        do_txn(0, 1'b0, 4'hF, 32'h88, 32'h0, 32'h00000002, 1'b0, "split_rd_bd");
        // Out-of-range backdoor is ignored (would alias word 0 if truncated).
        bd_we[0] = 1'b1; bd_addr[0] = 32'h100; bd_wdata[0] = 32'h77777777;
        step();
        bd_idle(0);
        do_txn(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "bd_oor_rd");

        // Grant delay: held request, dropped request, then a fresh request.
        gd_seq("gd_held");
        idle(1);
        begin
            int gcount;
            gcount = 0;
            for (int c = 1; c <= 8; c++) begin
                req[1] = (c <= 2); addr[1] = 32'h8;
                mid();
                if (gnt[1]) gcount++;
                step();
            end
            check("gd_drop_gnt_count", 64'(gcount), 64'd0);
            $display("txn gd_drop: %0d grant(s) after early drop", gcount);
        end
        idle(1);
        gd_seq("gd_after_drop");

        // RVALID_LAT=3: back-to-back write then read of word 0.
        for (int c = 1; c <= 7; c++) begin
            idle(2);
            if (c == 1) begin
                req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h0; wdata[2] = 32'h5;
            end
            if (c == 2) begin
                req[2] = 1'b1; addr[2] = 32'h0;
            end
            mid();
            check($sformatf("lat3_gnt c=%0d", c), 64'(gnt[2]), 64'(c <= 2));
            ex = (c == 4) ? mk(1'b1, 1'b0, 32'h0) : (c == 5) ? mk(1'b1, 1'b0, 32'h5) : 64'd0;
            check($sformatf("lat3_rsp c=%0d", c), rsp_of(2), ex);
            step();
        end
        $display("txn lat3 b2b write/read of word 0 done");

        // RVALID_LAT=3: reset one cycle after a grant drops the response.
        for (int c = 1; c <= 15; c++) begin
            idle(2);
            rst_n[2] = !(c >= 2 && c <= 4);
            if (c == 1 || c == 11) begin
                req[2] = 1'b1; addr[2] = 32'h0;
            end
            mid();
            check($sformatf("rst_gnt c=%0d", c), 64'(gnt[2]), 64'(c == 1 || c == 11));
            ex = (c == 14) ? mk(1'b1, 1'b0, 32'h5) : 64'd0;
            check($sformatf("rst_rsp c=%0d", c), rsp_of(2), ex);
            step();
        end
        $display("txn lat3 mid-flight reset done");

        // Randomized traffic on both zero-delay instances.
        preload();
        run_random(0, 1, 200);
        run_random(2, 3, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
